ycbcr_csc: RTL and testbench

- RGB888 to YCbCr444 colour-space converter for the frame-buffer pixel path.
- Sits directly downstream of the 512x8 coefficient RAM, using its read port (raddr/read_en/dout, 1-cycle registered read latency).
- After reset or on request, fetches nine signed coefficients from the RAM, then streams pixels through a 3-stage stallable pipeline with valid/ready handshakes on both sides.

---
 rtl/ycbcr_csc.sv | 152 +++++++++++++++
 tb/tb_ycbcr_csc.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_csc.sv
// RGB888 -> YCbCr444 converter. Fetches nine signed Q1.7 coefficients from an
// external coefficient RAM (1-cycle registered read), then streams pixels
// through a 3-stage stallable pipeline with valid/ready on both sides.
module ycbcr_csc #(
  parameter int COEF_BASE  = 0,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reload,
  output logic [ADDR_WIDTH-1:0] coef_raddr,
  output logic                  coef_re,
  input  logic [7:0]            coef_rdata,
  output logic                  loaded,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_r,
  input  logic [7:0]            s_g,
  input  logic [7:0]            s_b,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [7:0]            m_y,
  output logic [7:0]            m_cb,
  output logic [7:0]            m_cr
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         state_reg;
  // 0..8: address issue slots; 1..9: capture slots (data lags address by one)
  logic [3:0]         load_cnt_reg;
  logic signed [7:0]  coef_reg [9];

  logic               v1_reg;
  logic               v2_reg;
  logic               m_valid_reg;
  logic signed [16:0] prod_reg  [9];
  logic signed [16:0] prod_next [9];
  logic signed [18:0] sum_reg   [3];
  logic signed [18:0] sum_next  [3];
  logic [7:0]         pix_next  [3];
  logic [7:0]         out_reg   [3];
  logic [7:0]         comp      [3];

  logic stall;
  logic accept;
  logic pipe_empty;
  logic issuing;

  assign comp[0] = s_r;
  assign comp[1] = s_g;
  assign comp[2] = s_b;

  // The whole pipeline freezes while the output register holds an unconsumed pixel.
  assign stall      = m_valid_reg && !m_ready;
  assign s_ready    = (state_reg == ST_RUN) && !stall;
  assign accept     = s_valid && s_ready;
  assign pipe_empty = !v1_reg && !v2_reg && !m_valid_reg;
  assign loaded     = (state_reg == ST_RUN);

  // Read request is driven straight from the counter so address k appears in the
  // k-th cycle of LOAD; rst gates it so nothing is requested while held in reset.
  assign issuing    = (state_reg == ST_LOAD) && (load_cnt_reg < 4'd9);
  assign coef_re    = issuing && !rst;
  assign coef_raddr = ADDR_WIDTH'(COEF_BASE) + ADDR_WIDTH'(issuing ? load_cnt_reg : 4'd0);

  assign m_valid = m_valid_reg;
  assign m_y     = out_reg[0];
  assign m_cb    = out_reg[1];
  assign m_cr    = out_reg[2];

  genvar gi;
  generate
    // Products: coefficient index = 3*channel + component (R,G,B).
    for (gi = 0; gi < 9; gi++) begin : g_prod
      assign prod_next[gi] = 17'($signed({1'b0, comp[gi % 3]})) * 17'(coef_reg[gi]);
    end

    // Per-channel sum, then round, offset and clamp to 0..255.
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic signed [19:0] scaled;
      assign sum_next[gi] = 19'(prod_reg[3*gi]) + 19'(prod_reg[3*gi+1]) + 19'(prod_reg[3*gi+2]);
      assign scaled = ((20'(sum_reg[gi]) + 20'sd64) >>> 7) + ((gi == 0) ? 20'sd16 : 20'sd128);
      assign pix_next[gi] = scaled[19] ? 8'd0 :
                            (scaled > 20'sd255) ? 8'd255 : scaled[7:0];
    end
  endgenerate

  // Control FSM: coefficient fetch, run, and drain-before-reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_LOAD;
      load_cnt_reg <= 4'd0;
      for (int i = 0; i < 9; i++) coef_reg[i] <= 8'sd0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (load_cnt_reg != 4'd0) coef_reg[load_cnt_reg - 4'd1] <= coef_rdata;
          if (load_cnt_reg == 4'd9) begin
            state_reg    <= ST_RUN;
            load_cnt_reg <= 4'd0;
          end else begin
            load_cnt_reg <= load_cnt_reg + 4'd1;
          end
        end
        ST_RUN: begin
          if (reload) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            state_reg    <= ST_LOAD;
            load_cnt_reg <= 4'd0;
          end
        end
        default: begin
          state_reg    <= ST_LOAD;
          load_cnt_reg <= 4'd0;
        end
      endcase
    end
  end

  // Datapath: multiply, sum, scale; every stage advances together unless stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      m_valid_reg <= 1'b0;
      for (int i = 0; i < 9; i++) prod_reg[i] <= 17'sd0;
      for (int i = 0; i < 3; i++) begin
        sum_reg[i] <= 19'sd0;
        out_reg[i] <= 8'd0;
      end
    end else if (!stall) begin
      v1_reg      <= accept;
      v2_reg      <= v1_reg;
      m_valid_reg <= v2_reg;
      if (accept) begin
        for (int i = 0; i < 9; i++) prod_reg[i] <= prod_next[i];
      end
      if (v1_reg) begin
        for (int i = 0; i < 3; i++) sum_reg[i] <= sum_next[i];
      end
      if (v2_reg) begin
        for (int i = 0; i < 3; i++) out_reg[i] <= pix_next[i];
      end
    end
  end

endmodule

// File: tb/tb_ycbcr_csc.sv
// Self-checking bench for ycbcr_csc: coefficient RAM model, table vectors,
// randomized streaming against an integer reference model, reload and reset cases.
module tb_ycbcr_csc;

  localparam int BASE = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_d = 1'b1;
  logic       reload = 1'b0;
  logic [8:0] coef_raddr;
  logic       coef_re;
  logic [7:0] coef_rdata;
  logic       loaded;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_r = 8'd0, s_g = 8'd0, s_b = 8'd0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_y, m_cb, m_cr;

  always #5 clk = ~clk;

  ycbcr_csc #(.COEF_BASE(BASE), .ADDR_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .reload(reload),
    .coef_raddr(coef_raddr), .coef_re(coef_re), .coef_rdata(coef_rdata),
    .loaded(loaded),
    .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_g(s_g), .s_b(s_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_cb(m_cb), .m_cr(m_cr)
  );

  // Coefficient RAM with registered read
  logic [7:0] ram [0:511];
  always @(posedge clk) if (coef_re) coef_rdata <= ram[coef_raddr];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int set_a [9] = '{81, 90, -16, -112, 53, 34, 40, -16, 109};
  int set_b [9] = '{38, 75, 15, -22, -42, 64, 64, -54, -10};
  int mc [9];

  function automatic int floor_div128(input int v);
    int q;
    q = v / 128;
    if ((v % 128) != 0 && v < 0) q = q - 1;
    return q;
  endfunction

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic logic [23:0] model(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int acc;
    int res [3];
    for (int ch = 0; ch < 3; ch++) begin
      acc = mc[3*ch] * int'(r) + mc[3*ch+1] * int'(g) + mc[3*ch+2] * int'(b);
      res[ch] = clamp8(floor_div128(acc + 64) + ((ch == 0) ? 16 : 128));
    end
    return {8'(res[0]), 8'(res[1]), 8'(res[2])};
  endfunction

  task automatic load_ram(input int c [9]);
    for (int k = 0; k < 9; k++) ram[BASE + k] = 8'(c[k]);
  endtask

  task automatic use_model(input int c [9]);
    for (int k = 0; k < 9; k++) mc[k] = c[k];
  endtask

  // ---------------- per-cycle driver + scoreboard ----------------
  logic [23:0] exp_q [$];
  int          acc_q [$];
  int          cyc = 0;
  logic        got_out = 1'b0;
  logic        accepted = 1'b0;
  int          out_lat = 0;
  logic [23:0] last_out = 24'd0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_data = 24'd0;

  task automatic cycle(input logic sv, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic mr, input logic rl);
    logic [23:0] e;
    int a;
    @(posedge clk); #1;
    rst = rst_d; s_valid = sv; s_r = r; s_g = g; s_b = b; m_ready = mr; reload = rl;
    #1;
    cyc++;
    got_out = 1'b0;
    if (prev_stall && !rst) begin
      check("stall_valid_hold", int'(m_valid), 1);
      check("stall_data_hold", int'({m_y, m_cb, m_cr}), int'(prev_data));
    end
    if (m_valid && m_ready && !rst) begin
      check("out_has_expect", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("pixel_out", int'({m_y, m_cb, m_cr}), int'(e));
        got_out  = 1'b1;
        out_lat  = cyc - a;
        last_out = {m_y, m_cb, m_cr};
      end
    end
    accepted = s_valid && s_ready && !rst;
    if (accepted) begin
      exp_q.push_back(model(r, g, b));
      acc_q.push_back(cyc);
    end
    prev_stall = m_valid && !m_ready && !rst;
    prev_data  = {m_y, m_cb, m_cr};
  endtask

  task automatic idle();
    cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_raddr"},  int'(coef_raddr), BASE);
    check({tag, "_re"},     int'(coef_re), 0);
    check({tag, "_loaded"}, int'(loaded), 0);
    check({tag, "_sready"}, int'(s_ready), 0);
    check({tag, "_mvalid"}, int'(m_valid), 0);
    check({tag, "_mdata"},  int'({m_y, m_cb, m_cr}), 0);
  endtask

  // Release reset and follow the 9-address walk; loaded must rise on cycle 10.
  task automatic check_fetch(input string tag);
    rst_d = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      idle();
      check($sformatf("%s_re_c%0d", tag, c), int'(coef_re), (c < 9) ? 1 : 0);
      if (c < 9) check($sformatf("%s_addr_c%0d", tag, c), int'(coef_raddr), BASE + c);
      check($sformatf("%s_loaded_c%0d", tag, c), int'(loaded), (c == 10) ? 1 : 0);
    end
  endtask

  task automatic wait_loaded(input string tag);
    int n = 0;
    while (!loaded && n < 60) begin
      idle();
      if (!loaded) check({tag, "_sready_low"}, int'(s_ready), 0);
      n++;
    end
    check({tag, "_loaded_up"}, int'(loaded), 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      idle();
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic random_stream(input int n);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, 1'b0);
  endtask

  typedef struct {
    logic [7:0] r, g, b, y, cb, cr;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic done;
    int outs;
    int sent;

    // expected results for coefficient set B (38,75,15,-22,-42,64,64,-54,-10)
    tbl[0] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128};
    tbl[1] = '{8'd0,   8'd0,   8'd0,   8'd16,  8'd128, 8'd128};
    tbl[2] = '{8'd255, 8'd0,   8'd0,   8'd92,  8'd84,  8'd255};
    tbl[3] = '{8'd0,   8'd255, 8'd0,   8'd165, 8'd44,  8'd20};
    tbl[4] = '{8'd0,   8'd0,   8'd255, 8'd46,  8'd255, 8'd108};
    tbl[5] = '{8'd128, 8'd128, 8'd128, 8'd144, 8'd128, 8'd128};

    for (int i = 0; i < 512; i++) ram[i] = 8'd0;
    load_ram(set_a);
    use_model(set_a);

    // reset state and first coefficient fetch
    rst_d = 1'b1;
    repeat (3) idle();
    check_reset_vals("por");
    check_fetch("fetch");

    // randomized streaming with set A
    random_stream(60);
    drain("rand_a");

    // reload into set B
    load_ram(set_b);
    cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    check("reload_cycle_sready", int'(s_ready), 1);
    idle();
    check("reload_sready_drop", int'(s_ready), 0);
    check("reload_loaded_drop", int'(loaded), 0);
    wait_loaded("reload_b");
    use_model(set_b);

    // table vectors: value and exact 3-cycle latency
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, tbl[i].r, tbl[i].g, tbl[i].b, 1'b1, 1'b0);
      check($sformatf("tbl%0d_accept", i), int'(accepted), 1);
      n = 0;
      got_out = 1'b0;
      while (!got_out && n < 8) begin
        idle();
        n++;
      end
      check($sformatf("tbl%0d_seen", i), int'(got_out), 1);
      check($sformatf("tbl%0d_lat", i), out_lat, 3);
      check($sformatf("tbl%0d_y", i),  int'(last_out[23:16]), int'(tbl[i].y));
      check($sformatf("tbl%0d_cb", i), int'(last_out[15:8]),  int'(tbl[i].cb));
      check($sformatf("tbl%0d_cr", i), int'(last_out[7:0]),   int'(tbl[i].cr));
    end

    // backpressure: 8 distinct pixels, m_ready = 1,0,0,1,0,0,...
    sent = 0;
    outs = 0;
    for (int k = 0; k < 200 && outs < 8; k++) begin
      cycle(sent < 8, 8'(sent * 30 + 5), 8'(200 - sent * 20), 8'(sent * 17), (k % 3) == 0, 1'b0);
      if (accepted) sent++;
      if (got_out) outs++;
    end
    check("bp_outputs", outs, 8);
    check("bp_queue_empty", exp_q.size(), 0);

    // reload mid-stream: three pixels in flight keep set B results
    load_ram(set_a);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'(40 + i * 70), 8'(220 - i * 50), 8'(i * 100), 1'b1, 1'b0);
      check($sformatf("rl_accept%0d", i), int'(accepted), 1);
    end
    cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
    use_model(set_a);
    n = 0;
    done = 1'b0;
    while (!done && n < 80) begin
      cycle(1'b1, 8'd10, 8'd200, 8'd90, n >= 3, 1'b0);
      if (n == 0) check("rl_loaded_drop", int'(loaded), 0);
      if (!loaded) check("rl_sready_low", int'(s_ready), 0);
      if (accepted) done = 1'b1;
      n++;
    end
    check("rl_new_accept", int'(done), 1);
    drain("rl");

    // reset mid-LOAD at k=4
    cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    n = 0;
    while (!(coef_re && coef_raddr == 9'(BASE + 3)) && n < 30) begin
      idle();
      n++;
    end
    check("midload_k3_seen", int'(coef_re && coef_raddr == 9'(BASE + 3)), 1);
    rst_d = 1'b1;
    idle();
    check("midload_re_low", int'(coef_re), 0);
    idle();
    check_reset_vals("midload");
    exp_q.delete();
    acc_q.delete();
    check_fetch("refetch");
    random_stream(30);
    drain("rand_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
